regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised next-generation CPU register file: two asynchronous read ports, one synchronous write port, optional hardwired-zero register 0, optional write-to-read bypass.
- Adds a per-register scoreboard (busy bits) so the control unit can reserve a destination at issue, and detect read-after-write hazards via per-port valid flags.
- Sits in the datapath between decode (read/issue) and writeback (write/release).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZERO_REG, 1, if 1, register 0 reads 0, ignores writes, and is never busy.
- BYPASS, 1, if 1, same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReadRegNum1  in  ADDR_W  read port 1 index.
- ReadRegNum2  in  ADDR_W  read port 2 index.
- ReadData1  out  DATA_W  read port 1 data (combinational).
- ReadData2  out  DATA_W  read port 2 data (combinational).
- ReadValid1  out  1  port 1 data is not pending a write.
- ReadValid2  out  1  port 2 data is not pending a write.
- WriteRegNum  in  ADDR_W  writeback index.
- WriteData  in  DATA_W  writeback data.
- RegWrite  in  1  write enable; also releases the busy bit of WriteRegNum.
- IssueRegNum  in  ADDR_W  destination being reserved.
- Issue  in  1  reserve IssueRegNum (set busy).
- IssueConflict  out  1  registered; pulses 1 cycle after Issue targets an already-busy register.
- PendingCount  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (sync, active-high, priority over all else): every register = 0, all busy bits = 0, PendingCount = 0, IssueConflict = 0. Reset asserted mid-operation discards in-flight Issue/RegWrite in that cycle.
- Write: on posedge with RegWrite=1, reg[WriteRegNum] <= WriteData. If ZERO_REG=1 and WriteRegNum=0, the write is dropped.
- Read: ReadDataN = reg[ReadRegNumN], zero-latency combinational.
  - ZERO_REG=1 and index 0: ReadDataN = 0, ReadValidN = 1.
- Bypass (BYPASS=1): if RegWrite=1, WriteRegNum==ReadRegNumN, and the index is not the zero register, then ReadDataN = WriteData and ReadValidN = 1 in the same cycle.
- BYPASS=0: the read returns the old value until the next cycle. ReadValidN follows the busy bit only.
- ReadValidN = ~busy[ReadRegNumN], except for the bypass and zero-register cases above.
- Scoreboard update per posedge, not in reset:
  - Issue=1: busy[IssueRegNum] <= 1. Ignored for register 0 when ZERO_REG=1.
  - RegWrite=1: busy[WriteRegNum] <= 0.
  - Same index in the same cycle: the reservation wins, so the busy bit ends at 1 and the data is still written.
  - Issue to an already-busy index: busy stays 1, and IssueConflict = 1 on the next cycle only. The exception is a simultaneous RegWrite releasing that same index, which is not a conflict.
- PendingCount: registered, always equals the popcount of the busy vector after the update. Net change per cycle is in {-1, 0, +1}. It never exceeds 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.
- RegWrite to a non-busy register: legal, writes data, PendingCount unchanged.

Test Plan:
- Reset, then read indices 0..31 -> all ReadData = 0, ReadValid = 1, PendingCount = 0, IssueConflict = 0.
- Write reg5 = 0x0000_000F with ReadRegNum1 = 5 in the same cycle (BYPASS=1) -> ReadData1 = 0x0F that cycle; with BYPASS=0 -> old value 0, then 0x0F next cycle.
- Issue reg7 -> next cycle ReadValid2 = 0 for index 7, PendingCount = 1. RegWrite reg7 = 50 -> next cycle ReadValid2 = 1, ReadData2 = 50, PendingCount = 0.
- Issue reg3 twice on consecutive cycles -> IssueConflict = 1 exactly one cycle after the second Issue, PendingCount stays 1. Issue and RegWrite on reg3 together -> busy remains 1, data updated, no conflict.
- ZERO_REG=1: write reg0 = 0xDEAD_BEEF and Issue reg0 -> reads of reg0 return 0, ReadValid = 1, PendingCount unchanged.
- Issue regs 1, 2 and 4, then assert Reset in a cycle that also has RegWrite to reg1 = 99 -> next cycle all busy clear, PendingCount = 0, reg1 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: CPU register file with a destination scoreboard.
//   Two combinational read ports, one synchronous write port, optional
//   hardwired-zero register 0, optional same-cycle write-to-read bypass.
//   Per-register busy bits are set at issue and cleared at writeback, so
//   decode can see read-after-write hazards through ReadValid1/2.
// Ports:
//   clk, Reset                  clock, synchronous active-high reset
//   ReadRegNum1/2               read indices
//   ReadData1/2, ReadValid1/2   combinational read data and not-pending flags
//   WriteRegNum, WriteData      writeback index and data
//   RegWrite                    write enable; also releases the busy bit
//   IssueRegNum, Issue          destination reservation
//   IssueConflict               registered, issue hit an already-busy register
//   PendingCount                registered number of busy registers
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadRegNum1,
    input  logic [ADDR_W-1:0] ReadRegNum2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadValid1,
    output logic              ReadValid2,
    input  logic [ADDR_W-1:0] WriteRegNum,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] IssueRegNum,
    input  logic              Issue,
    output logic              IssueConflict,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              conflict_q, conflict_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, issue_en, issue_new, release_old;

    // Scoreboard next state; the count is tracked incrementally (+1/-1 per cycle).
    always_comb begin
        wr_en    = RegWrite && !(ZERO_EN && (WriteRegNum == '0));
        issue_en = Issue && !(ZERO_EN && (IssueRegNum == '0));

        busy_d = busy_q;
        if (RegWrite) begin
            busy_d[WriteRegNum] = 1'b0;
        end
        // Reservation applied last so it wins over a same-index release.
        if (issue_en) begin
            busy_d[IssueRegNum] = 1'b1;
        end

        conflict_d  = issue_en && busy_q[IssueRegNum]
                      && !(RegWrite && (WriteRegNum == IssueRegNum));
        issue_new   = issue_en && !busy_q[IssueRegNum];
        release_old = RegWrite && busy_q[WriteRegNum]
                      && !(issue_en && (IssueRegNum == WriteRegNum));
        count_d     = count_q + CNT_W'(issue_new) - CNT_W'(release_old);
    end

    // State registers; reset discards any same-cycle write or issue.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (wr_en) begin
                regs_q[WriteRegNum] <= WriteData;
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    // Read port 1: zero register first, then bypass, then storage.
    always_comb begin
        ReadData1  = regs_q[ReadRegNum1];
        ReadValid1 = !busy_q[ReadRegNum1];
        if (ZERO_EN && (ReadRegNum1 == '0)) begin
            ReadData1  = '0;
            ReadValid1 = 1'b1;
        end else if (BYP_EN && RegWrite && (WriteRegNum == ReadRegNum1)) begin
            ReadData1  = WriteData;
            ReadValid1 = 1'b1;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        ReadData2  = regs_q[ReadRegNum2];
        ReadValid2 = !busy_q[ReadRegNum2];
        if (ZERO_EN && (ReadRegNum2 == '0)) begin
            ReadData2  = '0;
            ReadValid2 = 1'b1;
        end else if (BYP_EN && RegWrite && (WriteRegNum == ReadRegNum2)) begin
            ReadData2  = WriteData;
            ReadValid2 = 1'b1;
        end
    end

    assign IssueConflict = conflict_q;
    assign PendingCount  = count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: two instances (zero-reg + bypass, and neither) driven by the
// same stimulus and compared every cycle against an array-based model.
module tb_regfile_sb;

    localparam int NR = 32;

    logic        clk;
    logic        Reset;
    logic [4:0]  rr1, rr2, wr, iss;
    logic [31:0] wd;
    logic        we, isu;

    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        v1 [2];
    logic        v2 [2];
    logic        conf_o [2];
    logic [5:0]  cnt_o [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: index 0 = ZERO_REG=1/BYPASS=1, index 1 = ZERO_REG=0/BYPASS=0
    logic [31:0] m_mem  [2][NR];
    bit          m_busy [2][NR];
    bit          m_conf [2];
    int          m_cnt  [2];

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_zb (
        .clk(clk), .Reset(Reset),
        .ReadRegNum1(rr1), .ReadRegNum2(rr2),
        .ReadData1(rd1[0]), .ReadData2(rd2[0]),
        .ReadValid1(v1[0]), .ReadValid2(v2[0]),
        .WriteRegNum(wr), .WriteData(wd), .RegWrite(we),
        .IssueRegNum(iss), .Issue(isu),
        .IssueConflict(conf_o[0]), .PendingCount(cnt_o[0])
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_plain (
        .clk(clk), .Reset(Reset),
        .ReadRegNum1(rr1), .ReadRegNum2(rr2),
        .ReadData1(rd1[1]), .ReadData2(rd2[1]),
        .ReadValid1(v1[1]), .ReadValid2(v2[1]),
        .WriteRegNum(wr), .WriteData(wd), .RegWrite(we),
        .IssueRegNum(iss), .Issue(isu),
        .IssueConflict(conf_o[1]), .PendingCount(cnt_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit zr(int k);
        return k == 0;
    endfunction

    function automatic bit byp(int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] exp_data(int k, logic [4:0] idx);
        if (zr(k) && idx == 5'd0) return 32'd0;
        if (byp(k) && we && wr == idx) return wd;
        return m_mem[k][idx];
    endfunction

    function automatic bit exp_valid(int k, logic [4:0] idx);
        if (zr(k) && idx == 5'd0) return 1'b1;
        if (byp(k) && we && wr == idx) return 1'b1;
        return !m_busy[k][idx];
    endfunction

    function automatic logic [4:0] pick_idx();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply the clock edge to the model using the inputs present at that edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                for (int i = 0; i < NR; i++) begin
                    m_mem[k][i]  = 32'd0;
                    m_busy[k][i] = 1'b0;
                end
                m_conf[k] = 1'b0;
            end else begin
                bit ie;
                ie = isu && !(zr(k) && iss == 5'd0);
                m_conf[k] = ie && m_busy[k][iss] && !(we && wr == iss);
                if (we && !(zr(k) && wr == 5'd0)) m_mem[k][wr] = wd;
                if (we) m_busy[k][wr] = 1'b0;
                if (ie) m_busy[k][iss] = 1'b1;
            end
            m_cnt[k] = 0;
            for (int i = 0; i < NR; i++) begin
                if (m_busy[k][i]) m_cnt[k]++;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rd1[%0d] idx%0d", k, rr1), rd1[k], exp_data(k, rr1));
            check_eq($sformatf("rd2[%0d] idx%0d", k, rr2), rd2[k], exp_data(k, rr2));
            check_eq($sformatf("v1[%0d] idx%0d", k, rr1), 32'(v1[k]), 32'(exp_valid(k, rr1)));
            check_eq($sformatf("v2[%0d] idx%0d", k, rr2), 32'(v2[k]), 32'(exp_valid(k, rr2)));
            check_eq($sformatf("conflict[%0d]", k), 32'(conf_o[k]), 32'(m_conf[k]));
            check_eq($sformatf("pending[%0d]", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic settle();
        #3;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic clear_in();
        Reset = 1'b0;
        we    = 1'b0;
        isu   = 1'b0;
        wr    = 5'd0;
        wd    = 32'd0;
        iss   = 5'd0;
    endtask

    initial begin
        rr1 = 5'd0;
        rr2 = 5'd0;
        clear_in();
        Reset = 1'b1;
        advance();
        clear_in();

        // All registers read zero and ready after reset
        for (int i = 0; i < NR; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(NR - 1 - i);
            settle();
            check_eq("rst_rd1", rd1[1], 32'd0);
            check_eq("rst_v1", 32'(v1[1]), 32'd1);
            advance();
        end
        check_eq("rst_pending", 32'(cnt_o[0]), 32'd0);
        check_eq("rst_conflict", 32'(conf_o[0]), 32'd0);

        // Write reg5 while reading it: bypass vs. next-cycle visibility
        clear_in();
        we = 1'b1; wr = 5'd5; wd = 32'h0000_000F; rr1 = 5'd5;
        settle();
        check_eq("byp_same_cycle", rd1[0], 32'h0000_000F);
        check_eq("nobyp_same_cycle", rd1[1], 32'd0);
        advance();
        clear_in();
        settle();
        check_eq("nobyp_next_cycle", rd1[1], 32'h0000_000F);
        advance();

        // Reserve reg7, then write it back
        clear_in();
        isu = 1'b1; iss = 5'd7; rr2 = 5'd7;
        tick();
        clear_in();
        settle();
        check_eq("r7_busy", 32'(v2[0]), 32'd0);
        check_eq("r7_pending", 32'(cnt_o[0]), 32'd1);
        advance();
        we = 1'b1; wr = 5'd7; wd = 32'd50;
        tick();
        clear_in();
        settle();
        check_eq("r7_valid", 32'(v2[1]), 32'd1);
        check_eq("r7_data", rd2[1], 32'd50);
        check_eq("r7_released", 32'(cnt_o[1]), 32'd0);
        advance();

        // Double issue of reg3 -> single-cycle conflict pulse
        clear_in();
        isu = 1'b1; iss = 5'd3;
        tick();
        tick();
        clear_in();
        settle();
        check_eq("r3_conflict", 32'(conf_o[0]), 32'd1);
        check_eq("r3_pending", 32'(cnt_o[0]), 32'd1);
        advance();
        settle();
        check_eq("r3_conflict_drop", 32'(conf_o[0]), 32'd0);
        advance();
        isu = 1'b1; iss = 5'd3; we = 1'b1; wr = 5'd3; wd = 32'h33; rr1 = 5'd3;
        tick();
        clear_in();
        settle();
        check_eq("r3_iw_noconflict", 32'(conf_o[1]), 32'd0);
        check_eq("r3_iw_busy", 32'(v1[1]), 32'd0);
        check_eq("r3_iw_data", rd1[1], 32'h33);
        check_eq("r3_iw_pending", 32'(cnt_o[1]), 32'd1);
        advance();

        // Register 0 ignores writes and reservations when hardwired
        we = 1'b1; wr = 5'd0; wd = 32'hDEAD_BEEF; isu = 1'b1; iss = 5'd0; rr1 = 5'd0;
        settle();
        check_eq("r0_same_data", rd1[0], 32'd0);
        check_eq("r0_same_valid", 32'(v1[0]), 32'd1);
        advance();
        clear_in();
        settle();
        check_eq("r0_data", rd1[0], 32'd0);
        check_eq("r0_valid", 32'(v1[0]), 32'd1);
        check_eq("r0_pending", 32'(cnt_o[0]), 32'd1);
        advance();

        // Reserve 1, 2, 4 then reset together with a write to reg1
        isu = 1'b1; iss = 5'd1; tick();
        iss = 5'd2; tick();
        iss = 5'd4; tick();
        clear_in();
        settle();
        check_eq("pre_rst_pending", 32'(cnt_o[0]), 32'd4);
        advance();
        Reset = 1'b1; we = 1'b1; wr = 5'd1; wd = 32'd99;
        tick();
        clear_in();
        rr1 = 5'd1;
        settle();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("post_rst_pending[%0d]", k), 32'(cnt_o[k]), 32'd0);
            check_eq($sformatf("post_rst_rd1[%0d]", k), rd1[k], 32'd0);
            check_eq($sformatf("post_rst_v1[%0d]", k), 32'(v1[k]), 32'd1);
        end
        advance();

        // Randomized traffic biased toward a few indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 99) == 0);
            we    = 1'($urandom_range(0, 1));
            isu   = 1'($urandom_range(0, 1));
            wr    = pick_idx();
            iss   = pick_idx();
            rr1   = pick_idx();
            rr2   = pick_idx();
            wd    = $urandom;
            tick();
        end
        clear_in();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
